// File: rtl/easyaxi_mst_rd_engine.sv
// easyaxi_mst_rd_engine: AXI4 read master with per-ID reorder slots.
// AR is issued and bursts retire strictly in command order.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif

module easyaxi_mst_rd_engine #(
  parameter int OST_DEPTH     = 8,
  parameter int MAX_BURST_LEN = 8,
  parameter int ID_W          = `AXI_ID_W,
  parameter int ADDR_W        = `AXI_ADDR_W,
  parameter int DATA_W        = `AXI_DATA_W,
  parameter int USER_W        = `AXI_USER_W,
  localparam int LW = $clog2(MAX_BURST_LEN),
  localparam int CW = $clog2(OST_DEPTH+1),
  localparam int SW = $clog2(OST_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LW-1:0]     cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [USER_W-1:0] cmd_user,
  output logic              axi_mst_arvalid,
  input  logic              axi_mst_arready,
  output logic [ID_W-1:0]   axi_mst_arid,
  output logic [ADDR_W-1:0] axi_mst_araddr,
  output logic [7:0]        axi_mst_arlen,
  output logic [2:0]        axi_mst_arsize,
  output logic [1:0]        axi_mst_arburst,
  output logic [USER_W-1:0] axi_mst_aruser,
  input  logic              axi_mst_rvalid,
  output logic              axi_mst_rready,
  input  logic [ID_W-1:0]   axi_mst_rid,
  input  logic [DATA_W-1:0] axi_mst_rdata,
  input  logic [1:0]        axi_mst_rresp,
  input  logic              axi_mst_rlast,
  input  logic [USER_W-1:0] axi_mst_ruser,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [DATA_W-1:0] cpl_data,
  output logic              cpl_last,
  output logic [1:0]        cpl_resp,
  output logic [USER_W-1:0] cpl_user,
  output logic [CW-1:0]     ost_cnt,
  output logic              err_unexp,
  output logic              err_len
);

  typedef enum logic [2:0] {
    S_FREE, S_PEND, S_WAIT, S_DONE, S_DRAIN
  } slot_st_e;

  slot_st_e          r_st    [OST_DEPTH];
  logic [ADDR_W-1:0] r_addr  [OST_DEPTH];
  logic [LW-1:0]     r_len   [OST_DEPTH];
  logic [2:0]        r_size  [OST_DEPTH];
  logic [1:0]        r_burst [OST_DEPTH];
  logic [USER_W-1:0] r_user  [OST_DEPTH];
  logic [LW:0]       r_cnt   [OST_DEPTH];
  logic [1:0]        r_resp  [OST_DEPTH];
  logic [DATA_W-1:0] r_buf   [OST_DEPTH][MAX_BURST_LEN];
  logic [SW-1:0]     r_fifo  [OST_DEPTH];
  logic [SW:0]       r_wr_ptr;
  logic [SW:0]       r_ar_ptr;
  logic [SW:0]       r_cpl_ptr;
  logic [LW-1:0]     r_beat;
  logic [CW-1:0]     r_ost;
  logic              r_err_unexp;
  logic              r_err_len;

  logic          w_any_free;
  logic [SW-1:0] w_alloc;
  logic          w_accept;
  logic [SW-1:0] w_ar_slot;
  logic          w_ar_valid;
  logic          w_ar_hs;
  logic [SW-1:0] w_rs;
  logic          w_rid_in;
  logic          w_r_ok;
  logic [LW:0]   w_r_len;
  logic          w_r_wr;
  logic          w_len_bad;
  logic [SW-1:0] w_cpl_slot;
  logic          w_cpl_valid;
  logic          w_cpl_last;
  logic          w_cpl_fire;
  logic          w_retire;
  logic          w_unused;

  // lowest-index FREE slot is the allocation target
  always_comb begin
    w_any_free = 1'b0;
    w_alloc    = '0;
    for (int s = OST_DEPTH-1; s >= 0; s--) begin
      if (r_st[s] == S_FREE) begin
        w_any_free = 1'b1;
        w_alloc    = SW'(s);
      end
    end
  end

  assign w_accept   = cmd_valid & w_any_free;
  assign w_ar_slot  = r_fifo[r_ar_ptr[SW-1:0]];
  assign w_ar_valid = (r_ar_ptr != r_wr_ptr) &&
                      (r_st[w_ar_slot] == S_PEND);
  assign w_ar_hs    = w_ar_valid & axi_mst_arready;

  assign w_rs      = axi_mst_rid[SW-1:0];
  assign w_rid_in  = (axi_mst_rid >> SW) == '0;
  assign w_r_ok    = axi_mst_rvalid && w_rid_in &&
                     (r_st[w_rs] == S_WAIT);
  assign w_r_len   = {1'b0, r_len[w_rs]};
  assign w_r_wr    = w_r_ok && (r_cnt[w_rs] <= w_r_len);
  assign w_len_bad = w_r_ok &&
                     (axi_mst_rlast ? (r_cnt[w_rs] != w_r_len)
                                    : (r_cnt[w_rs] >  w_r_len));

  assign w_cpl_slot  = r_fifo[r_cpl_ptr[SW-1:0]];
  assign w_cpl_valid = (r_cpl_ptr != r_wr_ptr) &&
                       ((r_st[w_cpl_slot] == S_DONE) ||
                        (r_st[w_cpl_slot] == S_DRAIN));
  assign w_cpl_last  = r_beat == r_len[w_cpl_slot];
  assign w_cpl_fire  = w_cpl_valid & cpl_ready;
  assign w_retire    = w_cpl_fire & w_cpl_last;

  // per-slot lifecycle and descriptor / response bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < OST_DEPTH; s++) begin
        r_st[s]    <= S_FREE;
        r_addr[s]  <= '0;
        r_len[s]   <= '0;
        r_size[s]  <= '0;
        r_burst[s] <= '0;
        r_user[s]  <= '0;
        r_cnt[s]   <= '0;
        r_resp[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < OST_DEPTH; s++) begin
        unique case (r_st[s])
          S_FREE: if (w_accept && w_alloc == SW'(s)) begin
            r_st[s]    <= S_PEND;
            r_addr[s]  <= cmd_addr;
            r_len[s]   <= cmd_len;
            r_size[s]  <= cmd_size;
            r_burst[s] <= cmd_burst;
            r_user[s]  <= cmd_user;
            r_cnt[s]   <= '0;
            r_resp[s]  <= 2'b00;
          end
          S_PEND: if (w_ar_hs && w_ar_slot == SW'(s))
            r_st[s] <= S_WAIT;
          S_WAIT: if (w_r_ok && w_rs == SW'(s)) begin
            if (w_r_wr)
              r_cnt[s] <= r_cnt[s] + (LW+1)'(1);
            if (axi_mst_rresp > r_resp[s])
              r_resp[s] <= axi_mst_rresp;
            if (axi_mst_rlast)
              r_st[s] <= S_DONE;
          end
          S_DONE, S_DRAIN: begin
            if (w_retire && w_cpl_slot == SW'(s))
              r_st[s] <= S_FREE;
            else if (w_cpl_valid && w_cpl_slot == SW'(s))
              r_st[s] <= S_DRAIN;
          end
          default: r_st[s] <= S_FREE;
        endcase
      end
    end
  end

  // beat storage; unwritten beats are masked to zero on read
  always_ff @(posedge clk) begin
    if (w_r_wr)
      r_buf[w_rs][r_cnt[w_rs][LW-1:0]] <= axi_mst_rdata;
  end

  // order FIFO pointers, completion beat index, counters, errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OST_DEPTH; i++)
        r_fifo[i] <= '0;
      r_wr_ptr    <= '0;
      r_ar_ptr    <= '0;
      r_cpl_ptr   <= '0;
      r_beat      <= '0;
      r_ost       <= '0;
      r_err_unexp <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr[SW-1:0]] <= w_alloc;
        r_wr_ptr <= r_wr_ptr + (SW+1)'(1);
      end
      if (w_ar_hs)
        r_ar_ptr <= r_ar_ptr + (SW+1)'(1);
      if (w_retire) begin
        r_cpl_ptr <= r_cpl_ptr + (SW+1)'(1);
        r_beat    <= '0;
      end else if (w_cpl_fire) begin
        r_beat <= r_beat + LW'(1);
      end
      if (w_accept && !w_retire)
        r_ost <= r_ost + CW'(1);
      else if (!w_accept && w_retire)
        r_ost <= r_ost - CW'(1);
      if (axi_mst_rvalid && !w_r_ok)
        r_err_unexp <= 1'b1;
      if (w_len_bad)
        r_err_len <= 1'b1;
    end
  end

  assign cmd_ready       = w_any_free;
  assign axi_mst_arvalid = w_ar_valid;
  assign axi_mst_arid    = ID_W'(w_ar_slot);
  assign axi_mst_araddr  = r_addr[w_ar_slot];
  assign axi_mst_arlen   = 8'(r_len[w_ar_slot]);
  assign axi_mst_arsize  = r_size[w_ar_slot];
  assign axi_mst_arburst = r_burst[w_ar_slot];
  assign axi_mst_aruser  = r_user[w_ar_slot];
  assign axi_mst_rready  = 1'b1;
  assign cpl_valid       = w_cpl_valid;
  assign cpl_data        = ({1'b0, r_beat} < r_cnt[w_cpl_slot])
                           ? r_buf[w_cpl_slot][r_beat] : '0;
  assign cpl_last        = w_cpl_last;
  assign cpl_resp        = r_resp[w_cpl_slot];
  assign cpl_user        = r_user[w_cpl_slot];
  assign ost_cnt         = r_ost;
  assign err_unexp       = r_err_unexp;
  assign err_len         = r_err_len;
  assign w_unused        = ^axi_mst_ruser;

endmodule

// File: tb/tb_easyaxi_mst_rd_engine.sv
// tb_easyaxi_mst_rd_engine: scoreboard bench for the AXI read engine.
// Expected AR and completion beats are queued as stimulus is driven.
module tb_easyaxi_mst_rd_engine;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int USER_W = 4;
  localparam int LW     = 3;
  localparam int CW     = 4;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              last;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } cpl_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [USER_W-1:0] user;
  } ar_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst;
  logic [USER_W-1:0] cmd_user;
  logic arvalid, arready;
  logic [ID_W-1:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [USER_W-1:0] aruser;
  logic rvalid, rready;
  logic [ID_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic [USER_W-1:0] ruser;
  logic cpl_valid, cpl_ready;
  logic [DATA_W-1:0] cpl_data;
  logic cpl_last;
  logic [1:0] cpl_resp;
  logic [USER_W-1:0] cpl_user;
  logic [CW-1:0] ost_cnt;
  logic err_unexp, err_len;

  int n_checks = 0;
  int n_pass   = 0;
  int n_tmo    = 0;
  int cyc      = 0;

  cpl_t exp_q[$];
  cpl_t obs_q[$];
  int   obs_cyc[$];
  ar_t  exp_ar[$];
  ar_t  obs_ar[$];

  easyaxi_mst_rd_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .cmd_user(cmd_user),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready),
    .axi_mst_arid(arid), .axi_mst_araddr(araddr),
    .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
    .axi_mst_arburst(arburst), .axi_mst_aruser(aruser),
    .axi_mst_rvalid(rvalid), .axi_mst_rready(rready),
    .axi_mst_rid(rid), .axi_mst_rdata(rdata),
    .axi_mst_rresp(rresp), .axi_mst_rlast(rlast),
    .axi_mst_ruser(ruser),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_data(cpl_data), .cpl_last(cpl_last),
    .cpl_resp(cpl_resp), .cpl_user(cpl_user),
    .ost_cnt(ost_cnt), .err_unexp(err_unexp),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record handshakes mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n && arvalid && arready)
      obs_ar.push_back('{arid, araddr, arlen, arsize,
                         arburst, aruser});
    if (rst_n && cpl_valid && cpl_ready) begin
      obs_q.push_back('{cpl_data, cpl_last, cpl_resp, cpl_user});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    exp_ar.delete();
    obs_ar.delete();
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] a,
                          input logic [LW-1:0] l,
                          input logic [USER_W-1:0] u,
                          input logic [ID_W-1:0] eid);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_size  = 3'd2;
    cmd_burst = 2'd1;
    cmd_user  = u;
    exp_ar.push_back('{eid, a, 8'(l), 3'd2, 2'd1, u});
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) n_tmo++;
  endtask

  task automatic r_beat(input logic [ID_W-1:0] i,
                        input logic [DATA_W-1:0] d,
                        input logic [1:0] rs,
                        input logic l);
    rvalid = 1'b1;
    rid    = i;
    rdata  = d;
    rresp  = rs;
    rlast  = l;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic wait_ar(input int n);
    for (int i = 0; i < 200 && obs_ar.size() < n; i++)
      tick();
    if (obs_ar.size() < n) n_tmo++;
  endtask

  task automatic wait_cpl(input int n);
    for (int i = 0; i < 300 && obs_q.size() < n; i++)
      tick();
    if (obs_q.size() < n) n_tmo++;
  endtask

  function automatic ar_t pop_ar();
    if (obs_ar.size() > 0) return obs_ar.pop_front();
    return '1;
  endfunction

  function automatic cpl_t pop_cpl(output int c);
    c = -1;
    if (obs_q.size() > 0) begin
      c = obs_cyc.pop_front();
      return obs_q.pop_front();
    end
    return '1;
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    got = {cmd_ready, arvalid, cpl_valid, ost_cnt,
           err_unexp, err_len, rready};
    n_checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got %b want 1000000001", got);
    else n_pass++;
  endtask

  task automatic test_single();
    int t0 = n_tmo;
    int c;
    ar_t ea, oa;
    cpl_t e, o;
    cpl_ready = 1'b0;
    send_cmd(32'h100, 3'd3, 4'd5, 4'd0);
    n_checks++;
    if (ost_cnt !== 4'd1)
      $display("FAIL t1_ost: got %0d want 1", ost_cnt);
    else n_pass++;
    wait_ar(1);
    ea = exp_ar.pop_front();
    oa = pop_ar();
    n_checks++;
    if (oa !== ea) $display("FAIL t1_ar: got %h want %h", oa, ea);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{DATA_W'(32'hD000_0000 + i), (i == 3),
                        2'd0, 4'd5});
      r_beat(4'd0, DATA_W'(32'hD000_0000 + i), 2'd0, (i == 3));
    end
    tick();
    tick();
    n_checks++;
    if ({cpl_valid, cpl_data} !== {1'b1, exp_q[0].d})
      $display("FAIL t1_stall: got %b/%h want 1/%h",
               cpl_valid, cpl_data, exp_q[0].d);
    else n_pass++;
    tick();
    n_checks++;
    if ({cpl_valid, cpl_data, cpl_last} !== {1'b1, exp_q[0].d, 1'b0})
      $display("FAIL t1_hold: got %b/%h/%b want 1/%h/0",
               cpl_valid, cpl_data, cpl_last, exp_q[0].d);
    else n_pass++;
    cpl_ready = 1'b1;
    wait_cpl(4);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      o = pop_cpl(c);
      n_checks++;
      if (o !== e) $display("FAIL t1_cpl%0d: got %h want %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (ost_cnt !== 4'd0 || n_tmo != t0)
      $display("FAIL t1_end: got ost %0d tmo %0d want 0 0",
               ost_cnt, n_tmo - t0);
    else n_pass++;
  endtask

  task automatic test_reorder();
    int t0 = n_tmo;
    int c[4];
    ar_t ea, oa;
    cpl_t e, o;
    send_cmd(32'h200, 3'd1, 4'd1, 4'd0);
    send_cmd(32'h240, 3'd1, 4'd2, 4'd1);
    wait_ar(2);
    for (int i = 0; i < 2; i++) begin
      ea = exp_ar.pop_front();
      oa = pop_ar();
      n_checks++;
      if (oa !== ea) $display("FAIL t2_ar%0d: got %h want %h", i, oa, ea);
      else n_pass++;
    end
    exp_q.push_back('{32'hA0, 1'b0, 2'd0, 4'd1});
    exp_q.push_back('{32'hA1, 1'b1, 2'd0, 4'd1});
    exp_q.push_back('{32'hB0, 1'b0, 2'd0, 4'd2});
    exp_q.push_back('{32'hB1, 1'b1, 2'd0, 4'd2});
    r_beat(4'd1, 32'hB0, 2'd0, 1'b0);
    r_beat(4'd1, 32'hB1, 2'd0, 1'b1);
    r_beat(4'd0, 32'hA0, 2'd0, 1'b0);
    r_beat(4'd0, 32'hA1, 2'd0, 1'b1);
    wait_cpl(4);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      o = pop_cpl(c[i]);
      n_checks++;
      if (o !== e) $display("FAIL t2_cpl%0d: got %h want %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (c[2] !== c[1] + 1 || n_tmo != t0)
      $display("FAIL t2_bubble: got gap %0d tmo %0d want 1 0",
               c[2] - c[1], n_tmo - t0);
    else n_pass++;
  endtask

  task automatic test_interleave();
    int t0 = n_tmo;
    int c;
    cpl_t e, o;
    send_cmd(32'h400, 3'd7, 4'd3, 4'd0);
    send_cmd(32'h500, 3'd7, 4'd4, 4'd1);
    wait_ar(2);
    for (int i = 0; i < 2; i++) void'(pop_ar());
    exp_ar.delete();
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{DATA_W'(32'h3000 + i), (i == 7), 2'd0, 4'd3});
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{DATA_W'(32'h4000 + i), (i == 7), 2'd2, 4'd4});
    for (int i = 0; i < 8; i++) begin
      r_beat(4'd0, DATA_W'(32'h3000 + i), 2'd0, (i == 7));
      r_beat(4'd1, DATA_W'(32'h4000 + i),
             (i == 4) ? 2'd2 : 2'd0, (i == 7));
    end
    wait_cpl(16);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      o = pop_cpl(c);
      n_checks++;
      if (o !== e) $display("FAIL t3_cpl%0d: got %h want %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (n_tmo != t0) $display("FAIL t3_tmo: got %0d want 0", n_tmo - t0);
    else n_pass++;
  endtask

  task automatic test_full();
    int t0 = n_tmo;
    int c;
    ar_t ea, oa;
    cpl_t e, o;
    for (int i = 0; i < 8; i++)
      send_cmd(ADDR_W'(32'h1000 + i * 16), 3'd0, USER_W'(i), ID_W'(i));
    wait_ar(8);
    n_checks++;
    if ({cmd_ready, ost_cnt} !== {1'b0, 4'd8})
      $display("FAIL t4_full: got rdy %b ost %0d want 0 8",
               cmd_ready, ost_cnt);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      ea = exp_ar.pop_front();
      oa = pop_ar();
      n_checks++;
      if (oa !== ea) $display("FAIL t4_ar%0d: got %h want %h", i, oa, ea);
      else n_pass++;
    end
    exp_q.push_back('{32'h5000, 1'b1, 2'd0, 4'd0});
    r_beat(4'd0, 32'h5000, 2'd0, 1'b1);
    n_checks++;
    if (cmd_ready !== 1'b0)
      $display("FAIL t4_pre: got rdy %b want 0", cmd_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({cmd_ready, ost_cnt} !== {1'b1, 4'd7})
      $display("FAIL t4_retire: got rdy %b ost %0d want 1 7",
               cmd_ready, ost_cnt);
    else n_pass++;
    send_cmd(32'h2000, 3'd0, 4'd8, 4'd0);
    wait_ar(1);
    ea = exp_ar.pop_front();
    oa = pop_ar();
    n_checks++;
    if (oa !== ea) $display("FAIL t4_reuse: got %h want %h", oa, ea);
    else n_pass++;
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back('{DATA_W'(32'h5000 + i), 1'b1, 2'd0, USER_W'(i)});
      r_beat(ID_W'(i), DATA_W'(32'h5000 + i), 2'd0, 1'b1);
    end
    exp_q.push_back('{32'h5100, 1'b1, 2'd0, 4'd8});
    r_beat(4'd0, 32'h5100, 2'd0, 1'b1);
    wait_cpl(9);
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      o = pop_cpl(c);
      n_checks++;
      if (o !== e) $display("FAIL t4_cpl%0d: got %h want %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (ost_cnt !== 4'd0 || n_tmo != t0)
      $display("FAIL t4_end: got ost %0d tmo %0d want 0 0",
               ost_cnt, n_tmo - t0);
    else n_pass++;
  endtask

  task automatic test_faults();
    int t0 = n_tmo;
    int c;
    cpl_t e, o;
    logic [4:0] got;
    r_beat(4'd3, 32'hDEAD, 2'd0, 1'b1);
    got = {err_unexp, err_len, cpl_valid, cmd_ready, arvalid};
    n_checks++;
    if (got !== 5'b10010 || ost_cnt !== 4'd0)
      $display("FAIL t5_unexp: got %b ost %0d want 10010 0",
               got, ost_cnt);
    else n_pass++;
    send_cmd(32'h300, 3'd2, 4'd6, 4'd0);
    wait_ar(1);
    void'(pop_ar());
    exp_ar.delete();
    exp_q.push_back('{32'h600, 1'b0, 2'd0, 4'd6});
    exp_q.push_back('{32'h601, 1'b0, 2'd0, 4'd6});
    exp_q.push_back('{32'h000, 1'b1, 2'd0, 4'd6});
    r_beat(4'd0, 32'h600, 2'd0, 1'b0);
    n_checks++;
    if (err_len !== 1'b0)
      $display("FAIL t5_len_pre: got %b want 0", err_len);
    else n_pass++;
    r_beat(4'd0, 32'h601, 2'd0, 1'b1);
    n_checks++;
    if (err_len !== 1'b1)
      $display("FAIL t5_len: got %b want 1", err_len);
    else n_pass++;
    wait_cpl(3);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = pop_cpl(c);
      n_checks++;
      if (o !== e) $display("FAIL t5_cpl%0d: got %h want %h", i, o, e);
      else n_pass++;
    end
    n_checks++;
    if (n_tmo != t0) $display("FAIL t5_tmo: got %0d want 0", n_tmo - t0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t0 = n_tmo;
    int c;
    logic [9:0] got;
    ar_t ea, oa;
    cpl_t e, o;
    for (int i = 0; i < 3; i++)
      send_cmd(ADDR_W'(32'h800 + i * 64), 3'd3, USER_W'(i + 1), ID_W'(i));
    wait_ar(3);
    r_beat(4'd0, 32'h8000, 2'd0, 1'b0);
    r_beat(4'd1, 32'h8100, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    got = {cmd_ready, arvalid, cpl_valid, ost_cnt,
           err_unexp, err_len, rready};
    n_checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL t6_reset: got %b want 1000000001", got);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    flush();
    tick();
    r_beat(4'd1, 32'h8101, 2'd0, 1'b1);
    n_checks++;
    if ({err_unexp, ost_cnt} !== {1'b1, 4'd0})
      $display("FAIL t6_late: got %b ost %0d want 1 0",
               err_unexp, ost_cnt);
    else n_pass++;
    send_cmd(32'h900, 3'd0, 4'd9, 4'd0);
    wait_ar(1);
    ea = exp_ar.pop_front();
    oa = pop_ar();
    n_checks++;
    if (oa !== ea) $display("FAIL t6_ar: got %h want %h", oa, ea);
    else n_pass++;
    exp_q.push_back('{32'h900, 1'b1, 2'd0, 4'd9});
    r_beat(4'd0, 32'h900, 2'd0, 1'b1);
    wait_cpl(1);
    e = exp_q.pop_front();
    o = pop_cpl(c);
    n_checks++;
    if (o !== e) $display("FAIL t6_cpl: got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if (n_tmo != t0) $display("FAIL t6_tmo: got %0d want 0", n_tmo - t0);
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_size  = '0;
    cmd_burst = '0;
    cmd_user  = '0;
    arready   = 1'b1;
    rvalid    = 1'b0;
    rid       = '0;
    rdata     = '0;
    rresp     = '0;
    rlast     = 1'b0;
    ruser     = '0;
    cpl_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_reorder();
    test_interleave();
    test_full();
    test_faults();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
